// File: rtl/digit_select_controller.sv
// digit_select_controller
//
// Scans the output-layer activations held in the sigmoid scratch memory
// (addresses BASE_ADDR .. BASE_ADDR+NUM_OUT-1) through a shared read port. It
// reports the index of the largest activation as the recognised digit. A scan
// starts on network_done. A new read is never issued while the network
// controller owns the memory (mem_busy). The result is held until the host
// acknowledges it.
//
// Ports:
//   clk           system clock
//   n_rst         synchronous active-low reset
//   network_done  one-cycle pulse: inference complete, scan may start
//   mem_busy      network controller owns the memory; no read may be issued
//   rd_data       read data, valid READ_LAT cycles after rd_en is registered
//   rd_en         read strobe (one-cycle pulse per neuron)
//   rd_addr       read address, held between reads
//   digit         index of the maximum activation
//   confidence    value of the maximum activation
//   result_valid  digit/confidence valid; held until result_ack
//   result_ack    consumer accepted the result
//   busy          scan in progress
//   overrun       one-cycle pulse: network_done while busy or result pending
module digit_select_controller #(
    parameter int NUM_OUT   = 10,
    parameter int BASE_ADDR = 8,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 4,
    parameter int READ_LAT  = 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              network_done,
    input  logic              mem_busy,
    input  logic [DATA_W-1:0] rd_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [3:0]        digit,
    output logic [DATA_W-1:0] confidence,
    output logic              result_valid,
    input  logic              result_ack,
    output logic              busy,
    output logic              overrun
);

    localparam int IdxW = $clog2(NUM_OUT);
    localparam int LatW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StCompare,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [LatW-1:0]     lat_q, lat_d;
    logic [DATA_W-1:0]   best_val_q, best_val_d;
    logic [IdxW-1:0]     best_idx_q, best_idx_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [3:0]          digit_q, digit_d;
    logic [DATA_W-1:0]   confidence_q, confidence_d;
    logic                result_valid_q, result_valid_d;
    logic                busy_q, busy_d;
    logic                overrun_q, overrun_d;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q        <= StIdle;
            idx_q          <= '0;
            lat_q          <= '0;
            best_val_q     <= '0;
            best_idx_q     <= '0;
            rd_en_q        <= 1'b0;
            rd_addr_q      <= '0;
            digit_q        <= '0;
            confidence_q   <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            lat_q          <= lat_d;
            best_val_q     <= best_val_d;
            best_idx_q     <= best_idx_d;
            rd_en_q        <= rd_en_d;
            rd_addr_q      <= rd_addr_d;
            digit_q        <= digit_d;
            confidence_q   <= confidence_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
            overrun_q      <= overrun_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        lat_d          = lat_q;
        best_val_d     = best_val_q;
        best_idx_d     = best_idx_q;
        rd_en_d        = 1'b0;
        rd_addr_d      = rd_addr_q;
        digit_d        = digit_q;
        confidence_d   = confidence_q;
        result_valid_d = result_valid_q;
        busy_d         = busy_q;
        overrun_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (network_done) begin
                    state_d = StIssue;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end

            StIssue: begin
                overrun_d = network_done;
                if (!mem_busy) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
                    lat_d     = '0;
                    state_d   = (READ_LAT == 1) ? StCompare : StWait;
                end
            end

            StWait: begin
                overrun_d = network_done;
                // READ_LAT-1 wait cycles: lat_q counts 0 .. READ_LAT-2
                if (lat_q == LatW'(READ_LAT - 2)) begin
                    state_d = StCompare;
                end else begin
                    lat_d = lat_q + LatW'(1);
                end
            end

            StCompare: begin
                overrun_d = network_done;
                // Strict compare keeps the lower index on ties
                if (idx_q == '0 || rd_data > best_val_q) begin
                    best_val_d = rd_data;
                    best_idx_d = idx_q;
                end
                if (idx_q == IdxW'(NUM_OUT - 1)) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + IdxW'(1);
                    state_d = StIssue;
                end
            end

            StDone: begin
                if (network_done) begin
                    // Restart drops any pending result; an ack in the same
                    // cycle retires the old result cleanly, so no overrun
                    overrun_d      = !(result_valid_q && result_ack);
                    result_valid_d = 1'b0;
                    state_d        = StIssue;
                    idx_d          = '0;
                    busy_d         = 1'b1;
                end else if (!result_valid_q) begin
                    // First DONE cycle: publish the registered best
                    digit_d        = 4'(best_idx_q);
                    confidence_d   = best_val_q;
                    result_valid_d = 1'b1;
                    busy_d         = 1'b0;
                end else if (result_ack) begin
                    result_valid_d = 1'b0;
                    state_d        = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign rd_en        = rd_en_q;
    assign rd_addr      = rd_addr_q;
    assign digit        = digit_q;
    assign confidence   = confidence_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;

endmodule

// File: doc/digit_select_controller.md
Name: digit_select_controller

Overview:
- Runs after the network controller finishes inference. Scans the output-layer neuron values in the sigmoid scratch memory (addresses BASE_ADDR..BASE_ADDR+NUM_OUT-1) through its shared read port and selects the index of the largest activation as the recognised digit.
- Gives way to the network controller whenever that controller owns the memory. Holds the result until the host side acknowledges it.

Parameters:
NUM_OUT, 10, number of output neurons scanned (2..16)
BASE_ADDR, 8, sigmoid memory address of output neuron 0
ADDR_W, 5, sigmoid memory address width
DATA_W, 4, activation width
READ_LAT, 1, cycles from rd_en to valid rd_data (1..3)

Ports:
clk  input  1  system clock
n_rst  input  1  synchronous active-low reset
network_done  input  1  one-cycle pulse: inference complete, output values stored
mem_busy  input  1  network controller owns the sigmoid memory; no read may be issued
rd_data  input  DATA_W  sigmoid memory read data, valid READ_LAT cycles after rd_en
rd_en  output  1  read strobe to sigmoid memory
rd_addr  output  ADDR_W  read address
digit  output  4  index of the maximum activation
confidence  output  DATA_W  value of the maximum activation
result_valid  output  1  digit/confidence valid; held until acknowledged
result_ack  input  1  consumer accepted the result
busy  output  1  scan in progress
overrun  output  1  one-cycle pulse: network_done arrived while busy or while a result was unacknowledged

Behaviour:
- Reset: one clock; reset is synchronous and active-low. When n_rst is sampled low at a clk edge:
  - state becomes IDLE;
  - rd_en, rd_addr, digit, confidence, result_valid, busy and overrun are all 0;
  - index counter, best value and latency counter are cleared.
  - This applies in every state, including mid-scan. Any in-flight read data is discarded.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, COMPARE, DONE.
- IDLE:
  - network_done=1 -> ISSUE; idx=0, busy=1.
- ISSUE:
  - If mem_busy=1: stay, rd_en=0.
  - Else: rd_en=1 for exactly one cycle, rd_addr=BASE_ADDR+idx, then -> WAIT.
  - rd_addr holds its value outside ISSUE; it is not re-zeroed.
- WAIT:
  - Waits READ_LAT-1 cycles, then -> COMPARE.
  - When READ_LAT=1, WAIT lasts 0 cycles and ISSUE goes straight to COMPARE.
- COMPARE (rd_data valid this cycle):
  - Update the best value and best index if idx==0 or rd_data > best_val (unsigned, strict).
  - Ties keep the lower index.
  - If idx==NUM_OUT-1 -> DONE. Else idx++ and -> ISSUE.
- DONE:
  - Entering DONE: digit=best_idx, confidence=best_val, result_valid=1, busy=0.
  - result_ack=1 -> result_valid=0 on the next edge, -> IDLE. digit and confidence hold their last values.
- Latency:
  - Measured from the edge that samples network_done, with no stalls.
  - result_valid rises after 1+NUM_OUT*(1+READ_LAT) cycles.
  - At the defaults (NUM_OUT=10, READ_LAT=1) that is 21 cycles.
  - Each cycle of mem_busy=1 in ISSUE adds one cycle.
- mem_busy is only sampled in ISSUE. A read already issued completes even if mem_busy rises afterwards.
- network_done arriving in ISSUE, WAIT or COMPARE:
  - Ignored for sequencing; overrun pulses for one cycle.
- network_done arriving in DONE before result_ack:
  - overrun pulses and result_valid drops.
  - The scan restarts (-> ISSUE, idx=0, busy=1). The stale result is dropped.
- network_done and result_ack in the same DONE cycle:
  - The ack is honoured, the restart proceeds and overrun stays 0.
- result_ack outside DONE: ignored.
- idx width: ceil(log2(NUM_OUT)). idx never wraps past NUM_OUT-1.

Test Plan:
- Values [1,3,7,2,0,5,6,4,2,1] at addrs 8..17, READ_LAT=1 -> rd_en pulses at addrs 8,9,...,17 on alternating cycles; result_valid rises 21 cycles after the done pulse; digit=2, confidence=7.
- Values all 9 except addr 12 and 15 = 15 -> digit=4 (lower index wins the tie), confidence=15.
- Hold mem_busy=1 for 5 cycles during the ISSUE for idx=3 -> rd_en stays low throughout, addr 11 is then issued, result_valid rises at cycle 26, result unchanged.
- Pulse network_done at cycle 10 of a scan -> overrun=1 for one cycle, scan unaffected, result correct. Pulse network_done in DONE without ack -> result_valid falls, overrun=1, new scan starts at addr 8.
- Drive n_rst low during WAIT of idx=6 -> the next edge shows all outputs 0 and state IDLE. Next network_done -> full scan from addr 8 with the correct result.
- READ_LAT=3, same data as the first test -> rd_en is spaced 4 cycles apart; result_valid rises at cycle 41; digit=2.
